// File: rtl/divu_core_param.sv
// divu_core_param
// Iterative restoring divider: a W-bit or 2W-bit dividend divided by a W-bit
// divisor, signed or unsigned, retiring K quotient bits per iteration cycle.
// The datapath works on magnitudes. Signs are reapplied in the FIX state,
// where signed overflow is also detected and saturation is applied.
// W must be even and at least 8. K must divide W (1, 2 or 4).

module divu_core_param #(
    parameter int W = 32,
    parameter int K = 1
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         CE,
    input  logic         START,
    input  logic         ABORT,
    input  logic         SIGNED,
    input  logic         LONG,
    input  logic         SAT_EN,
    input  logic [W-1:0] DVDNT_H,
    input  logic [W-1:0] DVDNT_L,
    input  logic [W-1:0] DVSR,
    output logic         BUSY,
    output logic         DONE,
    output logic [W-1:0] Q,
    output logic [W-1:0] R,
    output logic         OVF
);

    localparam int ITERS = W / K;
    localparam int CW    = $clog2(ITERS + 1);

    // Extreme signed quotient values, also used as the signed saturation values.
    localparam logic [W-1:0] SMIN = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] SMAX = {1'b0, {(W-1){1'b1}}};

    typedef enum logic [1:0] {
        IDLE,
        PREP,
        ITER,
        FIX
    } state_t;

    state_t state;
    state_t next_state;

    // Operands captured when START is accepted. Later input changes are ignored.
    logic         op_signed;
    logic         op_long;
    logic         op_sat;
    logic [W-1:0] op_h;
    logic [W-1:0] op_l;
    logic [W-1:0] op_dvsr;

    // Working registers for the magnitude division.
    logic           dvdnt_neg;
    logic           dvsr_neg;
    logic [W-1:0]   dvsr_mag;
    logic [W:0]     rem_reg;
    logic [W-1:0]   quo_reg;
    logic           ovf_pre;
    logic [CW-1:0]  cnt;

    // Combinational helpers.
    logic           accept;
    logic           finish;
    logic [2*W-1:0] full_dvdnt;
    logic           dvdnt_neg_c;
    logic [2*W-1:0] dvdnt_mag_c;
    logic           dvsr_neg_c;
    logic [W-1:0]   dvsr_mag_c;
    logic           ovf_pre_c;
    logic [W:0]     step_rem;
    logic [W-1:0]   step_quo;
    logic [W:0]     trial;
    logic           q_bit;
    logic           q_neg;
    logic           post_ovf;
    logic           ovf_final;
    logic [W-1:0]   sat_val;
    logic [W-1:0]   q_final;
    logic [W-1:0]   r_final;

    assign BUSY = (state != IDLE);

    // State register. Reset overrides the clock enable.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else if (CE) begin
            state <= next_state;
        end
    end

    // Next-state logic. ABORT returns to IDLE from every busy state, and it
    // also blocks a START that arrives in IDLE during the same cycle.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (START && !ABORT) begin
                    next_state = PREP;
                    accept     = 1'b1;
                end
            end
            PREP: begin
                if (ABORT) begin
                    next_state = IDLE;
                end else if (ovf_pre_c) begin
                    next_state = FIX;
                end else begin
                    next_state = ITER;
                end
            end
            ITER: begin
                if (ABORT) begin
                    next_state = IDLE;
                end else if (cnt == CW'(1)) begin
                    next_state = FIX;
                end
            end
            FIX: begin
                next_state = IDLE;
                finish     = !ABORT;
            end
            default: next_state = IDLE;
        endcase
    end

    // Operand preparation: build the 2W-bit dividend and take both magnitudes.
    // The quotient fits in W bits only if the high dividend word is below the divisor.
    always_comb begin
        if (op_long) begin
            full_dvdnt = {op_h, op_l};
        end else if (op_signed) begin
            full_dvdnt = {{W{op_l[W-1]}}, op_l};
        end else begin
            full_dvdnt = {{W{1'b0}}, op_l};
        end
        dvdnt_neg_c = op_signed & full_dvdnt[2*W-1];
        dvdnt_mag_c = dvdnt_neg_c ? -full_dvdnt : full_dvdnt;
        dvsr_neg_c  = op_signed & op_dvsr[W-1];
        dvsr_mag_c  = dvsr_neg_c ? -op_dvsr : op_dvsr;
        ovf_pre_c   = (op_dvsr == '0) || (dvdnt_mag_c[2*W-1:W] >= dvsr_mag_c);
    end

    // K restoring shift-subtract steps, unrolled for one iteration cycle.
    // The partial remainder is always below the divisor magnitude, so the
    // shifted trial value fits in W+1 bits.
    always_comb begin
        step_rem = rem_reg;
        step_quo = quo_reg;
        trial    = '0;
        q_bit    = 1'b0;
        for (int i = 0; i < K; i++) begin
            trial = {step_rem[W-1:0], step_quo[W-1]};
            if (trial >= {1'b0, dvsr_mag}) begin
                step_rem = trial - {1'b0, dvsr_mag};
                q_bit    = 1'b1;
            end else begin
                step_rem = trial;
                q_bit    = 1'b0;
            end
            step_quo = {step_quo[W-2:0], q_bit};
        end
    end

    // Result formation. Sign fixup truncates toward zero. Signed overflow is
    // detected on the magnitude, and results are saturated or zeroed on overflow.
    // A zero divisor has its sign bit clear, so it counts as positive.
    always_comb begin
        q_neg    = dvdnt_neg ^ dvsr_neg;
        post_ovf = 1'b0;
        if (op_signed) begin
            post_ovf = q_neg ? (quo_reg > SMIN) : (quo_reg > SMAX);
        end
        ovf_final = ovf_pre || post_ovf;

        if (!op_signed) begin
            sat_val = '1;
        end else if (q_neg) begin
            sat_val = SMIN;
        end else begin
            sat_val = SMAX;
        end

        if (ovf_final) begin
            q_final = op_sat ? sat_val : '0;
            r_final = '0;
        end else begin
            q_final = q_neg ? -quo_reg : quo_reg;
            r_final = dvdnt_neg ? -rem_reg[W-1:0] : rem_reg[W-1:0];
        end
    end

    // Datapath and result registers. Q, R and OVF change only together with DONE.
    always_ff @(posedge CLK) begin
        if (RST) begin
            op_signed <= 1'b0;
            op_long   <= 1'b0;
            op_sat    <= 1'b0;
            op_h      <= '0;
            op_l      <= '0;
            op_dvsr   <= '0;
            dvdnt_neg <= 1'b0;
            dvsr_neg  <= 1'b0;
            dvsr_mag  <= '0;
            rem_reg   <= '0;
            quo_reg   <= '0;
            ovf_pre   <= 1'b0;
            cnt       <= '0;
            DONE      <= 1'b0;
            Q         <= '0;
            R         <= '0;
            OVF       <= 1'b0;
        end else if (CE) begin
            DONE <= 1'b0;
            if (accept) begin
                op_signed <= SIGNED;
                op_long   <= LONG;
                op_sat    <= SAT_EN;
                op_h      <= DVDNT_H;
                op_l      <= DVDNT_L;
                op_dvsr   <= DVSR;
            end
            if (state == PREP) begin
                dvdnt_neg <= dvdnt_neg_c;
                dvsr_neg  <= dvsr_neg_c;
                dvsr_mag  <= dvsr_mag_c;
                rem_reg   <= {1'b0, dvdnt_mag_c[2*W-1:W]};
                quo_reg   <= dvdnt_mag_c[W-1:0];
                ovf_pre   <= ovf_pre_c;
                cnt       <= CW'(ITERS);
            end
            if (state == ITER) begin
                rem_reg <= step_rem;
                quo_reg <= step_quo;
                cnt     <= cnt - CW'(1);
            end
            if (finish) begin
                Q    <= q_final;
                R    <= r_final;
                OVF  <= ovf_final;
                DONE <= 1'b1;
            end
        end
    end

endmodule
